hqm_system_mem_pg_ctl: RTL and testbench

Single-clock power-gate sequencer and access front-end for one power-gated HQM system RF (default 64x6). It drives the RF's isolation and power-enable daisy-chain input and watches the chain's returned enable. After each power-up it optionally zero-initialises the array. While the array is not usable it blocks client reads and writes and flags them.

---
 rtl/hqm_mem_pg_pkg.sv | 17 +
 rtl/hqm_mem_pg_ack_sync.sv | 27 ++
 rtl/hqm_system_mem_pg_ctl.sv | 179 +++++++++++++++++
 tb/tb_hqm_system_mem_pg_ctl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hqm_mem_pg_pkg.sv
// Shared types and timing defaults for the HQM system RF power-gate controller.
package hqm_mem_pg_pkg;

  typedef enum logic [2:0] {
    OFF     = 3'd0,
    PWR_UP  = 3'd1,
    ISO_REL = 3'd2,
    INIT    = 3'd3,
    ON      = 3'd4,
    ISO_SET = 3'd5,
    PWR_DN  = 3'd6
  } hqm_mem_pg_state_t;

  localparam int HQM_MEM_PG_ISO_DLY = 4;
  localparam int HQM_MEM_PG_ACK_TMO = 255;

endpackage

// File: rtl/hqm_mem_pg_ack_sync.sv
// 2-flop synchroniser for the asynchronous power-enable chain acknowledge.
// Latency 2 cycles; no backpressure, samples every cycle.
module hqm_mem_pg_ack_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_s1;
  logic r_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= RST_VAL;
      r_s2 <= RST_VAL;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/hqm_system_mem_pg_ctl.sv
// Power-gate sequencer and client front-end for one power-gated HQM system RF.
// Reads: cl_re in N -> mem_re N+1 -> cl_rvalid N+2; accesses while not ready are dropped. Macro HQM_MEM_PG_INIT_EN adds zero-init.
module hqm_system_mem_pg_ctl
  import hqm_mem_pg_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int DWIDTH  = 6,
  parameter int AWIDTH  = 6,
  parameter int ISO_DLY = HQM_MEM_PG_ISO_DLY,
  parameter int ACK_TMO = HQM_MEM_PG_ACK_TMO
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pg_req_off,
  input  logic              cl_we,
  input  logic              cl_re,
  input  logic [AWIDTH-1:0] cl_waddr,
  input  logic [AWIDTH-1:0] cl_raddr,
  input  logic [DWIDTH-1:0] cl_wdata,
  output logic [DWIDTH-1:0] cl_rdata,
  output logic              cl_rvalid,
  output logic              mem_rdy,
  output logic              drop_err,
  output logic              tmo_err,
  output logic              mem_we,
  output logic              mem_re,
  output logic [AWIDTH-1:0] mem_waddr,
  output logic [AWIDTH-1:0] mem_raddr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic              pgcb_isol_en,
  output logic              pwr_enable_b,
  input  logic              pwr_enable_b_ack
);

  localparam logic [7:0]      L_ISO_LAST = 8'(ISO_DLY - 1);
  localparam logic [7:0]      L_ACK_TMO  = 8'(ACK_TMO);
  localparam logic [AWIDTH:0] L_DEPTH    = (AWIDTH + 1)'(DEPTH);

  hqm_mem_pg_state_t r_state;
  logic [7:0]        r_cnt;
  logic [AWIDTH:0]   r_init_cnt;
  logic              r_rvalid;
  logic [DWIDTH-1:0] r_rdata_last;
  logic              r_mem_rdy, r_drop_err, r_tmo_err;
  logic              r_pgcb_isol_en, r_pwr_enable_b;
  logic              r_mem_we, r_mem_re;
  logic [AWIDTH-1:0] r_mem_waddr, r_mem_raddr;
  logic [DWIDTH-1:0] r_mem_wdata;

  logic              w_ack_s;
  logic              w_rd_busy;
  logic              w_ack_tmo;
  logic [AWIDTH:0]   w_init_nxt;

  hqm_mem_pg_ack_sync #(.RST_VAL(1'b1)) u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (pwr_enable_b_ack),
    .o_q   (w_ack_s)
  );

  // A read anywhere in the request/return pipe holds off isolation.
  assign w_rd_busy  = cl_re | r_mem_re | r_rvalid;
  assign w_ack_tmo  = (r_cnt == L_ACK_TMO);
  assign w_init_nxt = r_init_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= OFF;
      r_cnt          <= '0;
      r_init_cnt     <= '0;
      r_rvalid       <= 1'b0;
      r_rdata_last   <= '0;
      r_mem_rdy      <= 1'b0;
      r_drop_err     <= 1'b0;
      r_tmo_err      <= 1'b0;
      r_pgcb_isol_en <= 1'b1;
      r_pwr_enable_b <= 1'b1;
      r_mem_we       <= 1'b0;
      r_mem_re       <= 1'b0;
      r_mem_waddr    <= '0;
      r_mem_raddr    <= '0;
      r_mem_wdata    <= '0;
    end else begin
      r_mem_we   <= 1'b0;
      r_mem_re   <= 1'b0;
      r_drop_err <= (cl_we | cl_re) & ~r_mem_rdy;
      r_rvalid   <= r_mem_re;
      r_cnt      <= r_cnt + 1'b1;
      if (r_rvalid) r_rdata_last <= mem_rdata;

      case (r_state)
        OFF: begin
          if (!pg_req_off) begin
            r_state        <= PWR_UP;
            r_pwr_enable_b <= 1'b0;
            r_cnt          <= '0;
          end
        end
        PWR_UP: begin
          if (!w_ack_s || w_ack_tmo) begin
            if (w_ack_s) r_tmo_err <= 1'b1;
            r_state        <= ISO_REL;
            r_pgcb_isol_en <= 1'b0;
            r_cnt          <= '0;
          end
        end
        ISO_REL: begin
          if (r_cnt == L_ISO_LAST) begin
            r_init_cnt <= '0;
`ifdef HQM_MEM_PG_INIT_EN
            r_state    <= INIT;
`else
            r_state    <= ON;
            r_mem_rdy  <= 1'b1;
`endif
          end
        end
        INIT: begin
          r_mem_we    <= 1'b1;
          r_mem_waddr <= r_init_cnt[AWIDTH-1:0];
          r_mem_wdata <= '0;
          r_init_cnt  <= w_init_nxt;
          if (w_init_nxt == L_DEPTH) begin
            r_state   <= ON;
            r_mem_rdy <= 1'b1;
          end
        end
        ON: begin
          if (cl_we) begin
            r_mem_we    <= 1'b1;
            r_mem_waddr <= cl_waddr;
            r_mem_wdata <= cl_wdata;
          end
          if (cl_re) begin
            r_mem_re    <= 1'b1;
            r_mem_raddr <= cl_raddr;
          end
          if (pg_req_off && !w_rd_busy) begin
            r_state        <= ISO_SET;
            r_pgcb_isol_en <= 1'b1;
            r_mem_rdy      <= 1'b0;
            r_cnt          <= '0;
          end
        end
        ISO_SET: begin
          if (r_cnt == L_ISO_LAST) begin
            r_state        <= PWR_DN;
            r_pwr_enable_b <= 1'b1;
            r_cnt          <= '0;
          end
        end
        PWR_DN: begin
          if (w_ack_s || w_ack_tmo) begin
            if (!w_ack_s) r_tmo_err <= 1'b1;
            r_state <= OFF;
          end
        end
        default: r_state <= OFF;
      endcase
    end
  end

  // Return data comes straight from the RF in the valid cycle, then is held.
  assign cl_rdata     = r_rvalid ? mem_rdata : r_rdata_last;
  assign cl_rvalid    = r_rvalid;
  assign mem_rdy      = r_mem_rdy;
  assign drop_err     = r_drop_err;
  assign tmo_err      = r_tmo_err;
  assign mem_we       = r_mem_we;
  assign mem_re       = r_mem_re;
  assign mem_waddr    = r_mem_waddr;
  assign mem_raddr    = r_mem_raddr;
  assign mem_wdata    = r_mem_wdata;
  assign pgcb_isol_en = r_pgcb_isol_en;
  assign pwr_enable_b = r_pwr_enable_b;

endmodule

// File: tb/tb_hqm_system_mem_pg_ctl.sv
// Scoreboard bench for hqm_system_mem_pg_ctl with a behavioural RF and power chain.
// Expectations adapt to whether HQM_MEM_PG_INIT_EN is defined.
module tb_hqm_system_mem_pg_ctl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pg_req_off = 1'b1;
  logic       cl_we = 1'b0, cl_re = 1'b0;
  logic [5:0] cl_waddr = '0, cl_raddr = '0, cl_wdata = '0;
  logic [5:0] cl_rdata;
  logic       cl_rvalid, mem_rdy, drop_err, tmo_err, mem_we, mem_re;
  logic [5:0] mem_waddr, mem_raddr, mem_wdata;
  logic [5:0] mem_rdata;
  logic       pgcb_isol_en, pwr_enable_b;
  logic       pwr_enable_b_ack = 1'b1;

  hqm_system_mem_pg_ctl dut (
    .clk(clk), .rst_n(rst_n), .pg_req_off(pg_req_off),
    .cl_we(cl_we), .cl_re(cl_re), .cl_waddr(cl_waddr), .cl_raddr(cl_raddr),
    .cl_wdata(cl_wdata), .cl_rdata(cl_rdata), .cl_rvalid(cl_rvalid),
    .mem_rdy(mem_rdy), .drop_err(drop_err), .tmo_err(tmo_err),
    .mem_we(mem_we), .mem_re(mem_re), .mem_waddr(mem_waddr), .mem_raddr(mem_raddr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .pgcb_isol_en(pgcb_isol_en), .pwr_enable_b(pwr_enable_b),
    .pwr_enable_b_ack(pwr_enable_b_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RF: registered read, old data on same-cycle collision.
  logic [5:0] rf [64];
  logic [5:0] rf_q = 6'h3F;
  initial for (int i = 0; i < 64; i++) rf[i] = 6'h3F;
  always @(posedge clk) begin
    if (mem_re) rf_q <= rf[mem_raddr];
    if (mem_we) rf[mem_waddr] <= mem_wdata;
  end
  assign mem_rdata = rf_q;

  // Power chain: ack follows pwr_enable_b three cycles later unless forced high.
  logic [2:0] ack_sr = 3'b111;
  logic       ack_force = 1'b0;
  initial forever begin
    @(posedge clk); #1;
    ack_sr = {ack_sr[1:0], pwr_enable_b};
    pwr_enable_b_ack = ack_force | ack_sr[2];
  end

  typedef struct { logic [5:0] d; int c; } rd_exp_t;
  typedef struct { logic [5:0] a; logic [5:0] d; } wr_t;
  rd_exp_t rd_q[$];
  int      drop_q[$];
  wr_t     wr_log[$];
  rd_exp_t mon_e;
  int      mon_c;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (cl_rvalid) begin
        if (rd_q.size() == 0) chk("rvalid_unexpected", 32'd1, 32'd0);
        else begin
          mon_e = rd_q.pop_front();
          chk("rd_data", {26'd0, cl_rdata}, {26'd0, mon_e.d});
          chk("rd_cycle", cyc, mon_e.c);
        end
      end
      if (drop_err) begin
        if (drop_q.size() == 0) chk("drop_unexpected", 32'd1, 32'd0);
        else begin
          mon_c = drop_q.pop_front();
          chk("drop_cycle", cyc, mon_c);
        end
      end
      if (mem_we) wr_log.push_back(wr_t'{mem_waddr, mem_wdata});
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [5:0] d);
    cl_we = 1'b1; cl_waddr = a; cl_wdata = d;
    tick();
    cl_we = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, input logic [5:0] exp);
    cl_re = 1'b1; cl_raddr = a;
    rd_q.push_back(rd_exp_t'{exp, cyc + 2});
    tick();
    cl_re = 1'b0;
  endtask

  task automatic drop_wr(input logic [5:0] a, input logic [5:0] d);
    drop_q.push_back(cyc + 1);
    wr(a, d);
  endtask

  task automatic drop_rd(input logic [5:0] a);
    drop_q.push_back(cyc + 1);
    cl_re = 1'b1; cl_raddr = a;
    tick();
    cl_re = 1'b0;
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_ctl"}, {24'd0, pwr_enable_b, pgcb_isol_en, mem_rdy, mem_we, mem_re,
                       cl_rvalid, drop_err, tmo_err}, 32'h0000_00C0);
    chk({nm, "_bus"}, {8'd0, mem_waddr, mem_raddr, mem_wdata, cl_rdata}, 32'd0);
  endtask

`ifdef HQM_MEM_PG_INIT_EN
  localparam int INIT_CYC = 64;
`else
  localparam int INIT_CYC = 0;
`endif

  int t0;
  int bad;

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) tick();
    chk_reset_outs("reset");
    rst_n = 1'b1;
    tick();

    // OFF: accesses dropped, nothing reaches the RF.
    drop_wr(6'd3, 6'h01);
    drop_rd(6'd4);
    tick();

    // Power-up: ack 3 cycles after enable, sync 2, iso 4, then init.
    pg_req_off = 1'b0;
    t0 = cyc;
    tick();
    chk("pwr_b_fall", {31'd0, pwr_enable_b}, 32'd0);
    drop_wr(6'd9, 6'h2F);
    for (int i = 0; i < 200 && !mem_rdy; i++) begin
      tick();
      if (mem_we && mem_waddr == 6'd10) drop_wr(6'd7, 6'h15);
    end
    chk("rdy_rise_cycle", cyc, t0 + 10 + INIT_CYC);
    chk("init_wr_count", wr_log.size(), INIT_CYC);
    bad = 0;
    foreach (wr_log[i]) if (wr_log[i].a != 6'(i) || wr_log[i].d != 6'd0) bad++;
    chk("init_wr_content", bad, 0);
    wr_log.delete();

    // ON: reads, writes, collision with a different read address.
`ifdef HQM_MEM_PG_INIT_EN
    rd(6'd5, 6'h00);
`endif
    wr(6'd63, 6'h2A);
    rd(6'd63, 6'h2A);
    wr(6'd0, 6'h15);
    cl_we = 1'b1; cl_waddr = 6'd1; cl_wdata = 6'h0C;
    cl_re = 1'b1; cl_raddr = 6'd63;
    rd_q.push_back(rd_exp_t'{6'h2A, cyc + 2});
    tick();
    cl_we = 1'b0; cl_re = 1'b0;
    rd(6'd1, 6'h0C);
    rd(6'd0, 6'h15);
    repeat (4) tick();
    chk("rdata_hold", {25'd0, cl_rvalid, cl_rdata}, {25'd0, 1'b0, 6'h15});
    chk("client_wr_count", wr_log.size(), 3);
    if (wr_log.size() > 0) chk("client_wr0", {20'd0, wr_log[0].a, wr_log[0].d}, {20'd0, 6'd63, 6'h2A});
    wr_log.delete();

    // Power-down with a read issued alongside the request.
    cl_re = 1'b1; cl_raddr = 6'd0; pg_req_off = 1'b1;
    rd_q.push_back(rd_exp_t'{6'h15, cyc + 2});
    t0 = cyc;
    tick();
    cl_re = 1'b0;
    for (int i = 0; i < 20 && !pgcb_isol_en; i++) tick();
    chk("isol_set_cycle", cyc, t0 + 4);
    chk("rdy_fall", {31'd0, mem_rdy}, 32'd0);
    pg_req_off = 1'b0;
    tick();
    pg_req_off = 1'b1;
    for (int i = 0; i < 20 && !pwr_enable_b; i++) tick();
    chk("pwr_b_rise_cycle", cyc, t0 + 8);
    repeat (10) tick();
    chk("off_state", {29'd0, pwr_enable_b, pgcb_isol_en, mem_rdy}, 32'd6);
    drop_wr(6'd2, 6'h33);
    repeat (3) tick();
    chk("off_no_wr", wr_log.size(), 0);
    chk("tmo_clear", {31'd0, tmo_err}, 32'd0);

    // Ack stuck high: timeout after 256 cycles in PWR_UP, sequence continues.
    ack_force = 1'b1;
    pg_req_off = 1'b0;
    t0 = cyc;
    for (int i = 0; i < 400 && !tmo_err; i++) tick();
    chk("tmo_cycle", cyc, t0 + 257);
    for (int i = 0; i < 200 && !mem_rdy; i++) tick();
    chk("tmo_rdy_cycle", cyc, t0 + 261 + INIT_CYC);
    ack_force = 1'b0;
    repeat (20) tick();
    chk("tmo_sticky", {31'd0, tmo_err}, 32'd1);
`ifdef HQM_MEM_PG_INIT_EN
    rd(6'd63, 6'h00);
`else
    rd(6'd63, 6'h2A);
`endif
    repeat (3) tick();
    wr_log.delete();

    // Full power-down, then reset in the middle of the next power-up.
    pg_req_off = 1'b1;
    for (int i = 0; i < 40 && !pwr_enable_b; i++) tick();
    repeat (8) tick();
    chk("off_again", {30'd0, pwr_enable_b, mem_rdy}, 32'd2);
    pg_req_off = 1'b0;
`ifdef HQM_MEM_PG_INIT_EN
    for (int i = 0; i < 200 && !(mem_we && mem_waddr == 6'd20); i++) tick();
    chk("init_at_20", {26'd0, mem_waddr}, 32'd20);
`else
    for (int i = 0; i < 200 && pgcb_isol_en; i++) tick();
    chk("iso_rel_seen", {31'd0, pgcb_isol_en}, 32'd0);
`endif
    rst_n = 1'b0;
    #1;
    chk_reset_outs("mid_reset");
    repeat (2) tick();
    chk("rd_q_empty", rd_q.size(), 0);
    chk("drop_q_empty", drop_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
